// File: rtl/seg7_pwm_scan.sv
// Multiplexed 8-digit common-anode hex display driver with frame-coherent input
// latching, leading-zero blanking, decimal points and phase-based PWM dimming.
module seg7_pwm_scan #(
    parameter int PWM_DIV = 12500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp,
    input  logic        lz_blank,
    input  logic [2:0]  brightness,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        frame_start
);

    localparam int CW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [CW-1:0] pwm_cnt_reg;
    logic [2:0]    phase_reg;
    logic [2:0]    idx_reg;

    logic [31:0]   value_sh_reg;
    logic [7:0]    en_sh_reg;
    logic [7:0]    dp_sh_reg;
    logic          lz_sh_reg;
    logic [2:0]    bright_sh_reg;

    logic [7:0]    an_reg;
    logic [6:0]    seg_reg;
    logic          dp_out_reg;
    logic          frame_start_reg;

    logic          pwm_wrap;
    logic          frame_latch;
    logic [7:0]    nz;
    logic [2:0]    high_idx;
    logic [7:0]    keep;
    logic [3:0]    cur_nib;
    logic          lit;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    assign pwm_wrap    = (pwm_cnt_reg == CW'(PWM_DIV - 1));
    assign frame_latch = (idx_reg == 3'd0) && (phase_reg == 3'd0) && (pwm_cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_reg <= '0;
            phase_reg   <= '0;
            idx_reg     <= '0;
        end else if (pwm_wrap) begin
            pwm_cnt_reg <= '0;
            phase_reg   <= phase_reg + 3'd1;
            if (phase_reg == 3'd7)
                idx_reg <= idx_reg + 3'd1;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + CW'(1);
        end
    end

    // Shadows are only loaded at the very start of a frame so a frame never mixes inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_sh_reg  <= '0;
            en_sh_reg     <= '0;
            dp_sh_reg     <= '0;
            lz_sh_reg     <= 1'b0;
            bright_sh_reg <= '0;
        end else if (frame_latch) begin
            value_sh_reg  <= value;
            en_sh_reg     <= digit_en;
            dp_sh_reg     <= dp;
            lz_sh_reg     <= lz_blank;
            bright_sh_reg <= brightness;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nz
            assign nz[gi] = |value_sh_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        high_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (nz[i])
                high_idx = 3'(i);
        end
    end

    // Digit 0 can never sit above the highest nonzero nibble, so it is never LZ-blanked.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_keep
            assign keep[gi] = en_sh_reg[gi] & ~(lz_sh_reg & (3'(gi) > high_idx));
        end
    endgenerate

    assign cur_nib = value_sh_reg[{idx_reg, 2'b00} +: 4];
    assign lit     = keep[idx_reg] && (phase_reg != 3'd0) && (phase_reg <= bright_sh_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            an_reg          <= 8'hFF;
            seg_reg         <= 7'h7F;
            dp_out_reg      <= 1'b1;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= frame_latch;
            if (lit) begin
                an_reg     <= ~(8'h01 << idx_reg);
                seg_reg    <= font(cur_nib);
                dp_out_reg <= ~dp_sh_reg[idx_reg];
            end else begin
                an_reg     <= 8'hFF;
                seg_reg    <= 7'h7F;
                dp_out_reg <= 1'b1;
            end
        end
    end

    assign AN          = an_reg;
    assign SEG         = seg_reg;
    assign DP          = dp_out_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg7_pwm_scan.sv
// Scoreboard bench for seg7_pwm_scan: a frame-timing model pushes the expected
// outputs before each clock edge and every test pops and compares after it.
module tb_seg7_pwm_scan;

    localparam int D     = 2;
    localparam int FRAME = 64 * D;

    logic        clk;
    logic        rst;
    logic [31:0] value;
    logic [7:0]  digit_en;
    logic [7:0]  dp;
    logic        lz_blank;
    logic [2:0]  brightness;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        frame_start;

    seg7_pwm_scan #(.PWM_DIV(D)) dut (
        .clk(clk), .rst(rst), .value(value), .digit_en(digit_en), .dp(dp),
        .lz_blank(lz_blank), .brightness(brightness),
        .AN(AN), .SEG(SEG), .DP(DP), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   t     = 0;

    logic [31:0] m_value;
    logic [7:0]  m_en;
    logic [7:0]  m_dp;
    logic        m_lz;
    logic [2:0]  m_br;
    logic [6:0]  font_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model one clock edge from the bench's own frame timer, then take the edge.
    task automatic advance();
        exp_t e;
        int   ph, id, h;
        logic [3:0] nib;
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.fs = 1'b0;
        if (rst) begin
            t = 0;
            m_value = '0; m_en = '0; m_dp = '0; m_lz = 1'b0; m_br = '0;
        end else begin
            if (t % FRAME == 0) begin
                m_value = value; m_en = digit_en; m_dp = dp; m_lz = lz_blank; m_br = brightness;
                e.fs = 1'b1;
            end
            ph = (t / D) % 8;
            id = (t / (8 * D)) % 8;
            h = 0;
            for (int i = 0; i < 8; i++)
                if (m_value[4*i +: 4] != 4'h0) h = i;
            nib = m_value[4*id +: 4];
            if (m_en[id] && !(m_lz && id > h) && ph >= 1 && ph <= int'(m_br)) begin
                e.an[id] = 1'b0;
                e.seg    = font_tbl[nib];
                e.dp     = ~m_dp[id];
            end
            t++;
        end
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        int fs_cnt = 0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            advance(); @(negedge clk); e = q.pop_front();
            total++;
            if ({AN, SEG, DP, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got AN=%h SEG=%h DP=%b fs=%b want FF 7F 1 0", c, AN, SEG, DP, frame_start);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            advance(); @(negedge clk); e = q.pop_front();
            total++;
            if ({AN, SEG, DP, frame_start} !== {e.an, e.seg, e.dp, e.fs}) begin
                bad++;
                $display("FAIL reset_scan cyc=%0d got %h %h %b %b want %h %h %b %b", c, AN, SEG, DP, frame_start, e.an, e.seg, e.dp, e.fs);
            end
            if (frame_start) fs_cnt++;
            if ((c == 0 || c == FRAME) && frame_start !== 1'b1) begin
                bad++;
                $display("FAIL frame_start_pos cyc=%0d got %b want 1", c, frame_start);
            end
        end
        total += 2;
        if (fs_cnt != 2) begin
            bad++;
            $display("FAIL frame_start_count got %0d want 2", fs_cnt);
        end
        $display("test_reset: done, frame_start pulses=%0d", fs_cnt);
    endtask

    task automatic test_scan();
        exp_t e;
        int d0 = 0, d1 = 0, hi = 0, multi = 0;
        for (int c = 0; c < FRAME; c++) begin
            advance(); @(negedge clk); e = q.pop_front();
            total++;
            if ({AN, SEG, DP, frame_start} !== {e.an, e.seg, e.dp, e.fs}) begin
                bad++;
                $display("FAIL scan cyc=%0d got %h %h %b %b want %h %h %b %b", c, AN, SEG, DP, frame_start, e.an, e.seg, e.dp, e.fs);
            end
            if (AN == 8'hFE && SEG == 7'h12) d0++;
            if (AN == 8'hFD && SEG == 7'h08) d1++;
            if (AN != 8'hFF && AN != 8'hFE && AN != 8'hFD && SEG == 7'h40) hi++;
            if ($countones(~AN) > 1) multi++;
        end
        total += 4;
        if (d0 != 14) begin bad++; $display("FAIL digit0_duty got %0d want 14", d0); end
        if (d1 != 14) begin bad++; $display("FAIL digit1_duty got %0d want 14", d1); end
        if (hi != 84) begin bad++; $display("FAIL upper_zero_digits got %0d want 84", hi); end
        if (multi != 0) begin bad++; $display("FAIL an_onehot got %0d bad cycles want 0", multi); end
        $display("test_scan: d0=%0d d1=%0d upper=%0d", d0, d1, hi);
    endtask

    task automatic test_brightness();
        exp_t e;
        int lit_cnt;
        for (int b = 1; b >= 0; b--) begin
            brightness = 3'(b);
            lit_cnt = 0;
            for (int c = 0; c < FRAME; c++) begin
                advance(); @(negedge clk); e = q.pop_front();
                total++;
                if ({AN, SEG, DP, frame_start} !== {e.an, e.seg, e.dp, e.fs}) begin
                    bad++;
                    $display("FAIL bright%0d cyc=%0d got %h %h %b %b want %h %h %b %b", b, c, AN, SEG, DP, frame_start, e.an, e.seg, e.dp, e.fs);
                end
                if (AN != 8'hFF) lit_cnt++;
            end
            total++;
            if (lit_cnt != 16 * b) begin
                bad++;
                $display("FAIL bright%0d_lit got %0d want %0d", b, lit_cnt, 16 * b);
            end
            $display("test_brightness: brightness=%0d lit=%0d", b, lit_cnt);
        end
        brightness = 3'd7;
    endtask

    task automatic test_lz();
        exp_t e;
        logic [31:0] vals [3] = '{32'h0000_0000, 32'h0001_0200, 32'h0000_0000};
        logic [7:0]  ens  [3] = '{8'hFF, 8'hFF, 8'hFE};
        int          want [3] = '{14, 70, 0};
        int lit_cnt, high_lit;
        lz_blank = 1'b1;
        for (int k = 0; k < 3; k++) begin
            value = vals[k]; digit_en = ens[k];
            lit_cnt = 0; high_lit = 0;
            for (int c = 0; c < FRAME; c++) begin
                advance(); @(negedge clk); e = q.pop_front();
                total++;
                if ({AN, SEG, DP, frame_start} !== {e.an, e.seg, e.dp, e.fs}) begin
                    bad++;
                    $display("FAIL lz%0d cyc=%0d got %h %h %b %b want %h %h %b %b", k, c, AN, SEG, DP, frame_start, e.an, e.seg, e.dp, e.fs);
                end
                if (AN != 8'hFF) lit_cnt++;
                if (AN[7:5] != 3'b111) high_lit++;
            end
            total += 2;
            if (lit_cnt != want[k]) begin bad++; $display("FAIL lz%0d_lit got %0d want %0d", k, lit_cnt, want[k]); end
            if (high_lit != 0) begin bad++; $display("FAIL lz%0d_high got %0d want 0", k, high_lit); end
            $display("test_lz: value=%h en=%h lit=%0d", vals[k], ens[k], lit_cnt);
        end
        lz_blank = 1'b0; digit_en = 8'hFF;
    endtask

    task automatic test_coherence();
        exp_t e;
        int s79 = 0, s24 = 0, s24_next = 0;
        value = 32'h1111_1111;
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c == 48) value = 32'h2222_2222;
            advance(); @(negedge clk); e = q.pop_front();
            total++;
            if ({AN, SEG, DP, frame_start} !== {e.an, e.seg, e.dp, e.fs}) begin
                bad++;
                $display("FAIL coherence cyc=%0d got %h %h %b %b want %h %h %b %b", c, AN, SEG, DP, frame_start, e.an, e.seg, e.dp, e.fs);
            end
            if (c < FRAME && c >= 48 && SEG == 7'h79) s79++;
            if (c < FRAME && SEG == 7'h24) s24++;
            if (c >= FRAME && SEG == 7'h24) s24_next++;
        end
        total += 3;
        if (s79 != 70) begin bad++; $display("FAIL coherence_old got %0d want 70", s79); end
        if (s24 != 0) begin bad++; $display("FAIL coherence_early got %0d want 0", s24); end
        if (s24_next != 112) begin bad++; $display("FAIL coherence_new got %0d want 112", s24_next); end
        $display("test_coherence: old=%0d early=%0d new=%0d", s79, s24, s24_next);
    endtask

    task automatic test_dp_reset();
        exp_t e;
        int dp_cnt = 0, dp_wrong = 0;
        dp = 8'h04; value = 32'h1111_1111;
        for (int c = 0; c < FRAME + 84; c++) begin
            advance(); @(negedge clk); e = q.pop_front();
            total++;
            if ({AN, SEG, DP, frame_start} !== {e.an, e.seg, e.dp, e.fs}) begin
                bad++;
                $display("FAIL dp cyc=%0d got %h %h %b %b want %h %h %b %b", c, AN, SEG, DP, frame_start, e.an, e.seg, e.dp, e.fs);
            end
            if (c < FRAME && DP == 1'b0) dp_cnt++;
            if (DP == 1'b0 && AN != 8'hFB) dp_wrong++;
        end
        total += 3;
        if (dp_cnt != 14) begin bad++; $display("FAIL dp_count got %0d want 14", dp_cnt); end
        if (dp_wrong != 0) begin bad++; $display("FAIL dp_placement got %0d want 0", dp_wrong); end
        if (AN !== 8'hDF) begin bad++; $display("FAIL pre_reset_digit5 got AN=%h want DF", AN); end
        rst = 1'b1;
        advance(); @(negedge clk); e = q.pop_front();
        total++;
        if ({AN, SEG, DP, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL midframe_reset got %h %h %b %b want FF 7F 1 0", AN, SEG, DP, frame_start);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            advance(); @(negedge clk); e = q.pop_front();
            total++;
            if ({AN, SEG, DP, frame_start} !== {e.an, e.seg, e.dp, e.fs}) begin
                bad++;
                $display("FAIL restart cyc=%0d got %h %h %b %b want %h %h %b %b", c, AN, SEG, DP, frame_start, e.an, e.seg, e.dp, e.fs);
            end
            if (c == 0) begin
                total++;
                if (frame_start !== 1'b1) begin bad++; $display("FAIL restart_fs got %b want 1", frame_start); end
            end
            if (c == 2) begin
                total++;
                if (AN !== 8'hFE) begin bad++; $display("FAIL restart_digit0 got AN=%h want FE", AN); end
            end
        end
        $display("test_dp_reset: dp_cycles=%0d", dp_cnt);
    endtask

    initial begin
        rst = 1'b1; value = 32'h0000_00A5; digit_en = 8'hFF; dp = 8'h00;
        lz_blank = 1'b0; brightness = 3'd7;
        test_reset();
        test_scan();
        test_brightness();
        test_lz();
        test_coherence();
        test_dp_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
